// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Purpose  : Multi-cycle restoring divider (one quotient bit per cycle) with
//            HI (remainder) / LO (quotient) result registers.
//            Define DIV_SIGNED_EN for signed (div) semantics; default is divu.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [CNT_W-1:0] count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(2);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quot_next;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    // One restoring step; the extra top bit holds the bit shifted out of rem.
    assign w_rem_sh    = {rem_q, quot_q[WIDTH-1]};
    assign w_sub       = w_rem_sh - {1'b0, dvsr_q};
    assign w_ge        = (w_rem_sh >= {1'b0, dvsr_q});
    assign w_rem_next  = w_ge ? w_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quot_next = {quot_q[WIDTH-2:0], w_ge};

`ifdef DIV_SIGNED_EN
    logic neg_quot_q, neg_quot_d;
    logic neg_rem_q, neg_rem_d;

    assign w_a_mag  = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign w_b_mag  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    assign w_res_lo = neg_quot_q ? (~w_quot_next + 1'b1) : w_quot_next;
    assign w_res_hi = neg_rem_q  ? (~w_rem_next + 1'b1)  : w_rem_next;

    always_comb begin
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        if (state_q == S_IDLE && start) begin
            neg_quot_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d  = dividend[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end
`else
    assign w_a_mag  = dividend;
    assign w_b_mag  = divisor;
    assign w_res_lo = w_quot_next;
    assign w_res_hi = w_rem_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (divisor == '0) ? S_FIN : S_RUN;
            S_RUN:  if (count_q == C_CNT_LAST) state_d = S_FIN;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_FIN);
    end

    // HI/LO are loaded on entry to FIN so they are already valid while done is high.
    always_comb begin
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvsr_d  = dvsr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        count_d = count_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dbz_d = (divisor == '0);
                    if (divisor == '0) begin
                        count_d = C_CNT_ONE;
                        hi_d    = dividend;
                        lo_d    = '1;
                    end else begin
                        count_d = C_CNT_FULL;
                        rem_d   = '0;
                        quot_d  = w_a_mag;
                        dvsr_d  = w_b_mag;
                    end
                end
            end
            S_RUN: begin
                rem_d  = w_rem_next;
                quot_d = w_quot_next;
                if (count_q != '0) count_d = count_q - 1'b1;
                if (count_q == C_CNT_LAST) begin
                    hi_d = w_res_hi;
                    lo_d = w_res_lo;
                end
            end
            S_FIN:   count_d = '0;
            default: count_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            quot_q  <= '0;
            dvsr_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            count_q <= '0;
            dbz_q   <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dvsr_q  <= dvsr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            count_q <= count_d;
            dbz_q   <= dbz_d;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign count       = count_q;
    assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Randomized self-checking bench for div_unit against a
//            transaction-level arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;
    logic [6:0]  count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32), .CNT_W(7)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo),
        .count       (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: quotient and remainder straight from / and %.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
`ifdef DIV_SIGNED_EN
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
`else
        q = a / b;
        r = a % b;
`endif
    endfunction

    // Model state: cycles left until idle, visible results, pending results.
    int          m_cnt;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_dbz;

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] q, r;
        if (!rst_n) begin
            m_cnt <= 0;
            m_hi  <= '0;
            m_lo  <= '0;
            m_phi <= '0;
            m_plo <= '0;
            m_dbz <= 1'b0;
        end else if (m_cnt == 0) begin
            if (start) begin
                if (divisor == 0) begin
                    m_cnt <= 1;
                    m_hi  <= dividend;
                    m_lo  <= 32'hFFFF_FFFF;
                    m_dbz <= 1'b1;
                end else begin
                    ref_div(dividend, divisor, q, r);
                    m_cnt <= 33;
                    m_phi <= r;
                    m_plo <= q;
                    m_dbz <= 1'b0;
                end
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) begin
                m_hi <= m_phi;
                m_lo <= m_plo;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy",  {31'b0, busy},        {31'b0, m_cnt != 0});
        chk("done",  {31'b0, done},        {31'b0, m_cnt == 1});
        chk("count", {25'b0, count},       32'(m_cnt));
        chk("dbz",   {31'b0, div_by_zero}, {31'b0, m_dbz});
        chk("hi",    hi, m_hi);
        chk("lo",    lo, m_lo);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        tick();
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #2;
            seen = done;
        end
        chk(name, {31'b0, seen}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && busy; i++) tick();
        chk("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        int sel;

        repeat (2) tick();
        chk("rst_hi",    hi, 32'd0);
        chk("rst_lo",    lo, 32'd0);
        chk("rst_count", {25'b0, count}, 32'd0);
        rst_n = 1'b1;

        // 100 / 7
        do_start(32'd100, 32'd7);
        #1;
        chk("t1_count0", {25'b0, count}, 32'd33);
        chk("t1_busy",   {31'b0, busy},  32'd1);
        wait_done("t1_done");
        chk("t1_count_fin", {25'b0, count}, 32'd1);
`ifdef DIV_SIGNED_EN
        chk("t1_lo", lo, 32'd14);
        chk("t1_hi", hi, 32'd2);
`else
        chk("t1_lo", lo, 32'd14);
        chk("t1_hi", hi, 32'd2);
        do_start(32'hFFFF_FFFF, 32'd1);
        wait_done("t2_done");
        chk("t2_lo", lo, 32'hFFFF_FFFF);
        chk("t2_hi", hi, 32'd0);
`endif

        // Divide by zero, then a normal divide clears the flag
        do_start(32'd55, 32'd0);
        #1;
        chk("t3_done", {31'b0, done},        32'd1);
        chk("t3_dbz",  {31'b0, div_by_zero}, 32'd1);
        chk("t3_lo",   lo, 32'hFFFF_FFFF);
        chk("t3_hi",   hi, 32'd55);
        do_start(32'd9, 32'd3);
        #1;
        chk("t3_dbz_clr", {31'b0, div_by_zero}, 32'd0);
        wait_done("t3b_done");
        chk("t3b_lo", lo, 32'd3);
        chk("t3b_hi", hi, 32'd0);

        // Start while busy is ignored
        do_start(32'd100, 32'd7);
        repeat (8) tick();
        start = 1'b1; dividend = 32'd8; divisor = 32'd2;
        tick();
        start = 1'b0;
        wait_done("t4_done");
        chk("t4_lo", lo, 32'd14);
        chk("t4_hi", hi, 32'd2);

        // Asynchronous reset mid-divide
        do_start(32'd100, 32'd7);
        repeat (13) tick();
        rst_n = 1'b0;
        #1;
        chk("t5_busy",  {31'b0, busy}, 32'd0);
        chk("t5_count", {25'b0, count}, 32'd0);
        chk("t5_hi",    hi, 32'd0);
        chk("t5_lo",    lo, 32'd14 & 32'd0);
        tick();
        rst_n = 1'b1;
        do_start(32'd20, 32'd6);
        wait_done("t5b_done");
        chk("t5b_lo", lo, 32'd3);
        chk("t5b_hi", hi, 32'd2);

`ifdef DIV_SIGNED_EN
        do_start(-32'sd7, 32'd2);
        wait_done("t6a_done");
        chk("t6a_lo", lo, 32'hFFFF_FFFD);
        chk("t6a_hi", hi, 32'hFFFF_FFFF);
        do_start(32'd7, -32'sd2);
        wait_done("t6b_done");
        chk("t6b_lo", lo, 32'hFFFF_FFFD);
        chk("t6b_hi", hi, 32'd1);
`endif
        wait_idle();

        // Random traffic including stray starts while busy and during FIN
        for (int n = 0; n < 60; n++) begin
            a   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      b = 32'd0;
            else if (sel < 4)  b = $urandom_range(1, 15);
            else if (sel < 6)  b = a >> $urandom_range(0, 31);
            else               b = $urandom;
`ifdef DIV_SIGNED_EN
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
`endif
            do_start(a, b);
            repeat ($urandom_range(0, 40)) begin
                start    = ($urandom_range(0, 3) == 0);
                dividend = $urandom;
                divisor  = $urandom_range(0, 1) ? 32'd0 : $urandom;
`ifdef DIV_SIGNED_EN
                if (dividend == 32'h8000_0000 && divisor == 32'hFFFF_FFFF) divisor = 32'd1;
`endif
                tick();
            end
            start = 1'b0;
            wait_idle();
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
